imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate generator for the decode stage of the RISC-V core.
- Extends the single-cycle combinational generator:
  - XLEN 32/64.
  - U-type (LUI/AUIPC) and CSR zimm formats.
  - Format tag and illegal-opcode flag on the output.
  - Valid/ready handshake with a 2-entry skid buffer.
  - Flush input.
  - Saturating illegal-instruction counter.
- Sits between instruction fetch and the register-read/ALU-operand mux in the pipelined core.

---
 rtl/rv_pkg.sv | 90 +++++++++
 rtl/imm_dec_comb.sv | 22 ++
 rtl/imm_gen_pipe.sv | 96 +++++++++
 tb/tb_imm_gen_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: opcodes, immediate format tags and the immediate decoder.
// Pure combinational helpers. The same decode is shared by the single-cycle and pipelined cores.
package rv_pkg;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [63:0] imm;
    imm_type_e   typ;
    logic        illegal;
  } imm_dec_t;

  // Immediate is always built at 64 bits; narrower cores take the low bits.
  function automatic imm_dec_t imm_decode(input logic [31:0] instr, input int xlen,
                                          input logic en_csr);
    imm_dec_t d;
    d.imm     = '0;
    d.typ     = IMM_NONE;
    d.illegal = 1'b0;
    case (instr[6:2])
      OPC_OP: ;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        d.typ = IMM_I;
        d.imm = {{52{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        d.typ = IMM_S;
        d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        d.typ = IMM_B;
        d.imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        d.typ = IMM_J;
        d.imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        d.typ = IMM_U;
        d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        if (en_csr) begin
          d.typ = IMM_Z;
          d.imm = {59'b0, instr[19:15]};
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        if (xlen == 64) begin
          d.typ = IMM_I;
          d.imm = {{52{instr[31]}}, instr[31:20]};
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_32: d.illegal = (xlen != 64);
      default:   d.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) d.illegal = 1'b1;
    if (d.illegal) begin
      d.imm = '0;
      d.typ = IMM_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/imm_dec_comb.sv
// Combinational immediate decoder: format tag, XLEN-wide immediate, illegal flag.
// Zero latency, no flow control; reusable by the single-cycle core.
module imm_dec_comb
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  imm_dec_t dec;

  assign dec        = imm_decode(instr_i, XLEN, EN_CSR);
  assign imm_o      = dec.imm[XLEN-1:0];
  assign imm_type_o = dec.typ;
  assign illegal_o  = dec.illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: 1-cycle latency into a 2-entry (head + skid) buffer.
// in_ready_o is registered (skid empty), so upstream never sees a path from out_ready_i.
module imm_gen_pipe
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit EN_CSR = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_data_o,
  output logic [XLEN-1:0]  imm_data_o,
  output logic [2:0]       imm_type_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic            illegal;
  } entry_t;

  entry_t           head_q, skid_q, in_ent;
  logic             head_vld_q, skid_vld_q;
  logic [CNT_W-1:0] ill_cnt_q;
  logic [XLEN-1:0]  dec_imm;
  imm_type_e        dec_typ;
  logic             dec_ill;
  logic             accept, deliver;

  imm_dec_comb #(
    .XLEN   (XLEN),
    .EN_CSR (EN_CSR)
  ) u_dec (
    .instr_i    (instr_data_i),
    .imm_o      (dec_imm),
    .imm_type_o (dec_typ),
    .illegal_o  (dec_ill)
  );

  assign in_ent  = '{instr: instr_data_i, imm: dec_imm, typ: dec_typ, illegal: dec_ill};
  assign accept  = in_valid_i && !skid_vld_q;
  assign deliver = head_vld_q && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else if (flush_i) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (deliver && head_q.illegal && !(&ill_cnt_q)) ill_cnt_q <= ill_cnt_q + 1'b1;
      // Skid only holds data while the head is occupied, so it always drains into the head.
      if (deliver) begin
        if (skid_vld_q) begin
          head_q     <= skid_q;
          skid_vld_q <= 1'b0;
        end else if (accept) begin
          head_q <= in_ent;
        end else begin
          head_vld_q <= 1'b0;
        end
      end else if (accept) begin
        if (!head_vld_q) begin
          head_q     <= in_ent;
          head_vld_q <= 1'b1;
        end else begin
          skid_q     <= in_ent;
          skid_vld_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o   = !skid_vld_q;
  assign out_valid_o  = head_vld_q;
  assign instr_data_o = head_q.instr;
  assign imm_data_o   = head_q.imm;
  assign imm_type_o   = head_q.typ;
  assign illegal_o    = head_q.illegal;
  assign ill_cnt_o    = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Three configurations (RV32, RV64, RV32 without CSR and a 2-bit counter) share one stimulus
// stream; each is compared against a queue model with an arithmetic immediate reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;

  logic [2:0]  in_rdy, out_vld;
  logic [31:0] o_instr [3];
  logic [2:0]  typ [3];
  logic        ill [3];
  logic [31:0] imm32, imm32s;
  logic [63:0] imm64;
  logic [15:0] cnt32, cnt64;
  logic [1:0]  cnts;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  int          m_cnt [3] = '{0, 0, 0};
  int          xl [3]    = '{32, 64, 32};
  bit          ec [3]    = '{1'b1, 1'b1, 1'b0};
  int          cmax [3]  = '{65535, 65535, 3};
  string       nm [3]    = '{"x32.", "x64.", "s32."};
  logic [4:0]  ops [13]  = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b11011, 5'b01101,
                             5'b00101, 5'b11100, 5'b00110, 5'b01110, 5'b01100, 5'b01010};

  localparam logic [31:0] ADDI = 32'hFFF00093, LUI = 32'h800000B7, BEQ = 32'hFE000EE3,
                          CSRI = 32'h3400D073, OP32 = 32'h0000003B;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b1), .CNT_W(16)) u_x32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_rdy[0]),
    .instr_data_i(instr), .out_valid_o(out_vld[0]), .out_ready_i(out_ready),
    .instr_data_o(o_instr[0]), .imm_data_o(imm32), .imm_type_o(typ[0]), .illegal_o(ill[0]),
    .ill_cnt_o(cnt32));

  imm_gen_pipe #(.XLEN(64), .EN_CSR(1'b1), .CNT_W(16)) u_x64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_rdy[1]),
    .instr_data_i(instr), .out_valid_o(out_vld[1]), .out_ready_i(out_ready),
    .instr_data_o(o_instr[1]), .imm_data_o(imm64), .imm_type_o(typ[1]), .illegal_o(ill[1]),
    .ill_cnt_o(cnt64));

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b0), .CNT_W(2)) u_s32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_rdy[2]),
    .instr_data_i(instr), .out_valid_o(out_vld[2]), .out_ready_i(out_ready),
    .instr_data_o(o_instr[2]), .imm_data_o(imm32s), .imm_type_o(typ[2]), .illegal_o(ill[2]),
    .ill_cnt_o(cnts));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference immediate from the format rules, using weighted field sums.
  function automatic void ref_dec(input logic [31:0] i, input int xlen, input bit en_csr,
                                  output logic [63:0] imm, output int t, output bit bad);
    longint v;
    v = 0; t = 0; bad = 1'b0;
    case (i[6:2])
      5'b01100: ;
      5'b00100, 5'b00000, 5'b11001: begin t = 1; v = longint'($signed(i[31:20])); end
      5'b01000: begin
        t = 2;
        v = (i[31] ? -longint'(2048) : 0) + longint'(i[30:25]) * 32 + longint'(i[11:7]);
      end
      5'b11000: begin
        t = 3;
        v = (i[31] ? -longint'(4096) : 0) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
            + longint'(i[11:8]) * 2;
      end
      5'b11011: begin
        t = 5;
        v = (i[31] ? -longint'(1 << 20) : 0) + longint'(i[19:12]) * 4096
            + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      5'b01101, 5'b00101: begin
        t = 4;
        v = (i[31] ? -(longint'(1) << 31) : 0) + longint'(i[30:12]) * 4096;
      end
      5'b11100: if (en_csr) begin t = 6; v = longint'(i[19:15]); end else bad = 1'b1;
      5'b00110: if (xlen == 64) begin t = 1; v = longint'($signed(i[31:20])); end else bad = 1'b1;
      5'b01110: bad = (xlen != 64);
      default:  bad = 1'b1;
    endcase
    if (i[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin v = 0; t = 0; end
    imm = v;
    if (xlen == 32) imm[63:32] = '0;
  endfunction

  task automatic check_one(input int k, input logic vld, input logic rdy, input logic [31:0] ins,
                           input logic [63:0] imm, input logic [2:0] t, input logic il,
                           input logic [31:0] cnt, input bit zero);
    logic [63:0] ei;
    int          et;
    bit          eb;
    check({nm[k], "out_valid"}, vld, q.size() > 0);
    check({nm[k], "in_ready"}, rdy, q.size() < 2);
    check({nm[k], "ill_cnt"}, cnt, m_cnt[k]);
    if (q.size() > 0) begin
      ref_dec(q[0], xl[k], ec[k], ei, et, eb);
      check({nm[k], "instr"}, ins, q[0]);
      check({nm[k], "imm"}, imm, ei);
      check({nm[k], "type"}, t, et);
      check({nm[k], "illegal"}, il, eb);
    end else if (zero) begin
      check({nm[k], "rst_instr"}, ins, 0);
      check({nm[k], "rst_imm"}, imm, 0);
      check({nm[k], "rst_type"}, t, 0);
      check({nm[k], "rst_illegal"}, il, 0);
    end
  endtask

  task automatic check_all(input bit zero);
    check_one(0, out_vld[0], in_rdy[0], o_instr[0], {32'b0, imm32}, typ[0], ill[0], {16'b0, cnt32}, zero);
    check_one(1, out_vld[1], in_rdy[1], o_instr[1], imm64, typ[1], ill[1], {16'b0, cnt64}, zero);
    check_one(2, out_vld[2], in_rdy[2], o_instr[2], {32'b0, imm32s}, typ[2], ill[2], {30'b0, cnts}, zero);
  endtask

  // Check the current cycle, drive the next one, and advance the model to match that edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    bit          acc, del;
    logic [63:0] ei;
    int          et;
    bit          eb;
    @(negedge clk);
    check_all(1'b0);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    if (fl) begin
      q.delete();
    end else begin
      acc = v && (q.size() < 2);
      del = (q.size() > 0) && ordy;
      if (del) begin
        for (int k = 0; k < 3; k++) begin
          ref_dec(q[0], xl[k], ec[k], ei, et, eb);
          if (eb && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
        void'(q.pop_front());
      end
      if (acc) q.push_back(ins);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = {ops[$urandom_range(0, 12)], 2'b11};
    return r;
  endfunction

  initial begin
    #7;
    check_all(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, ADDI, 1, 0); step(0, 0, 1, 0);
    check("addi_vld", out_vld[0], 1); check("addi_imm", imm32, 32'hFFFFFFFF);
    check("addi_type", typ[0], 1);    check("addi_ill", ill[0], 0);

    step(1, LUI, 1, 0); step(0, 0, 1, 0);
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000); check("lui_type", typ[1], 4);
    step(1, BEQ, 1, 0); step(0, 0, 1, 0);
    check("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC); check("beq_type", typ[1], 3);
    step(1, CSRI, 1, 0); step(0, 0, 1, 0);
    check("csr_imm64", imm64, 64'd1); check("csr_type", typ[1], 6); check("csr_nocsr_ill", ill[2], 1);

    step(1, 32'h0, 1, 0); step(1, OP32, 1, 0);
    check("ill0_flag", ill[0], 1); check("ill0_imm", imm32, 0); check("ill0_cnt", cnt32, 0);
    step(0, 0, 1, 0);
    check("ill1_flag", ill[0], 1); check("ill1_cnt", cnt32, 1); check("op32_x64_ill", ill[1], 0);
    step(0, 0, 1, 0);
    check("ill2_cnt", cnt32, 2);

    for (int n = 0; n < 5; n++) step(1, 32'h0, 1, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    check("sat_cnt", cnts, 2'd3); check("cnt16_after5", cnt32, 7);

    step(1, ADDI, 0, 0); step(1, LUI, 0, 0); step(1, BEQ, 0, 0);
    check("bp_in_ready", in_rdy[0], 0); check("bp_head", o_instr[0], ADDI);
    step(1, BEQ, 1, 0); step(1, BEQ, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);

    step(1, ADDI, 0, 0); step(1, 32'h0, 0, 0); step(1, LUI, 0, 1); step(0, 0, 0, 0);
    check("flush_vld", out_vld[0], 0); check("flush_rdy", in_rdy[0], 1); check("flush_cnt", cnt32, 7);

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    step(1, ADDI, 0, 0); step(1, LUI, 0, 0); step(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    q.delete();
    m_cnt = '{0, 0, 0};
    #1 check_all(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step(1, rand_instr(), 1, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
